// File: rtl/uart_rx_latch.sv
// UART 8N1 receiver with a one-deep holding register, ready/ack handshake,
// framing-error pulse and sticky overrun flag.
module uart_rx_latch #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(2);

    if (CLKS_PER_BIT < 4) begin : g_param_check
        $error("uart_rx_latch: CLKS_PER_BIT must be >= 4");
    end

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             rx_meta;
    logic             rxs;
    logic             stop_done;
    logic             commit;

    // Two-flop synchroniser; reset to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            // NOTE: non-blocking so rxs takes the previous rx_meta, giving two real stages.
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
        end
    end

    assign stop_done = (state == S_STOP) && (cnt == CNT_LAST);
    assign commit    = stop_done && rxs;
    assign rx_busy   = (state == S_START) || (state == S_DATA) || (state == S_STOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RESYNC;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            case (state)
                // The synchroniser still holds its reset value for two cycles,
                // so the line level is only trusted once those have elapsed.
                S_RESYNC: begin
                    if (cnt != CNT_SETTLE) begin
                        cnt <= cnt + 1'b1;
                    end else if (rxs) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= S_DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rxs;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= rxs ? S_IDLE : S_RESYNC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_RESYNC;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Holding register and handshake; an ack in the commit cycle consumes the
    // old byte so the new one loads without raising overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= 8'h00;
            rx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_valid  <= commit;
            frame_err <= stop_done && !rxs;
            if (commit) begin
                rx_data  <= shift_reg;
                rx_ready <= 1'b1;
                if (rx_ack) begin
                    overrun <= 1'b0;
                end else if (rx_ready) begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_ready <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule
